// File: rtl/datapath_sequencer.sv
// Control sequencer for the shared 32-bit bus datapath.
// Each cycle it selects one bus source and raises the load enables of the
// registers that capture the bus. It fetches an instruction through a memory
// read handshake, then executes register-to-register operations decoded from IR.
//
// Memory handshake: mem_read is held high for every cycle spent in T1. A cycle
// with mem_read=1 and mem_ready=1 completes the read: MDR loads in that same
// cycle and the sequencer moves to T2. mem_ready has no effect in any other
// state. If TIMEOUT consecutive T1 cycles pass without mem_ready, fault is set
// and the sequencer parks in HALTED.
module datapath_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [4:0]  bus_sel,
   output logic [15:0] reg_in,
   output logic        pc_in,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic        inc_pc,
   output logic [2:0]  alu_op,
   output logic        mem_read,
   output logic        busy,
   output logic        halted,
   output logic        fault,
   output logic        illegal,
   output logic [3:0]  dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_T0     = 4'd1,
      S_T1     = 4'd2,
      S_T2     = 4'd3,
      S_T3     = 4'd4,
      S_T4     = 4'd5,
      S_T5     = 4'd6,
      S_T6     = 4'd7,
      S_HALTED = 4'd8
   } state_t;

   localparam logic [4:0] SEL_PC   = 5'd16;
   localparam logic [4:0] SEL_HI   = 5'd17;
   localparam logic [4:0] SEL_LO   = 5'd18;
   localparam logic [4:0] SEL_ZHI  = 5'd19;
   localparam logic [4:0] SEL_ZLO  = 5'd20;
   localparam logic [4:0] SEL_MDR  = 5'd21;
   localparam logic [4:0] SEL_NONE = 5'd31;

   // Last counter value before the wait budget is exhausted.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       fault_set;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       unused_ir;

   assign op = ir[31:27];
   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];
   assign unused_ir = ^ir[14:0];

   assign dbg_state = state;

   // State, memory wait counter and sticky fault flag; clr clears all at once.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_IDLE;
         wait_cnt <= 8'd0;
         fault    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (fault_set) fault <= 1'b1;
      end
   end

   // Next-state selection, wait counting and timeout detection.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      fault_set    = 1'b0;
      case (state)
         S_IDLE: if (run) state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1: begin
            if (mem_ready) begin
               state_nxt    = S_T2;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt    = S_HALTED;
               wait_cnt_nxt = 8'd0;
               fault_set    = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_T2: state_nxt = S_T3;
         S_T3: begin
            case (op)
               5'd0, 5'd1, 5'd2, 5'd3, 5'd4: state_nxt = S_T4;
               5'd31:                        state_nxt = S_HALTED;
               default:                      state_nxt = S_T0;
            endcase
         end
         S_T4:     state_nxt = S_T5;
         S_T5:     state_nxt = (op == 5'd4) ? S_T6 : S_T0;
         S_T6:     state_nxt = S_T0;
         S_HALTED: state_nxt = S_HALTED;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Moore control word: one bus source plus capture enables for each state.
   always_comb begin
      bus_sel  = SEL_NONE;
      reg_in   = 16'h0000;
      pc_in    = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      z_in     = 1'b0;
      mar_in   = 1'b0;
      mdr_in   = 1'b0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      inc_pc   = 1'b0;
      alu_op   = 3'd0;
      mem_read = 1'b0;
      illegal  = 1'b0;
      busy     = (state != S_IDLE) && (state != S_HALTED);
      halted   = (state == S_HALTED);
      case (state)
         S_T0: begin
            bus_sel = SEL_PC;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            z_in    = 1'b1;
         end
         S_T1: begin
            // PC reloads from ZLO on every wait cycle; ZLO is stable, so harmless.
            bus_sel  = SEL_ZLO;
            pc_in    = 1'b1;
            mem_read = 1'b1;
            mdr_in   = mem_ready;
         end
         S_T2: begin
            bus_sel = SEL_MDR;
            ir_in   = 1'b1;
         end
         S_T3: begin
            case (op)
               5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
                  bus_sel = {1'b0, rb};
                  y_in    = 1'b1;
               end
               5'd5: begin
                  bus_sel = SEL_HI;
                  reg_in  = 16'h0001 << ra;
               end
               5'd6: begin
                  bus_sel = SEL_LO;
                  reg_in  = 16'h0001 << ra;
               end
               5'd7, 5'd31: ;
               default: illegal = 1'b1;
            endcase
         end
         S_T4: begin
            bus_sel = {1'b0, rc};
            alu_op  = op[2:0];
            z_in    = 1'b1;
         end
         S_T5: begin
            bus_sel = SEL_ZLO;
            if (op == 5'd4) lo_in  = 1'b1;
            else            reg_in = 16'h0001 << ra;
         end
         S_T6: begin
            bus_sel = SEL_ZHI;
            hi_in   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer. The driver pushes the expected
// control word for every cycle it drives; a negedge monitor pops and compares.
module tb_datapath_sequencer;

   localparam int W = 42;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_T0     = 4'd1;
   localparam logic [3:0] S_T1     = 4'd2;
   localparam logic [3:0] S_T2     = 4'd3;
   localparam logic [3:0] S_T3     = 4'd4;
   localparam logic [3:0] S_T4     = 4'd5;
   localparam logic [3:0] S_T5     = 4'd6;
   localparam logic [3:0] S_T6     = 4'd7;
   localparam logic [3:0] S_HALTED = 4'd8;

   // enable byte order: pc, ir, y, z, mar, mdr, hi, lo
   localparam logic [7:0] EN_PC  = 8'h80;
   localparam logic [7:0] EN_IR  = 8'h40;
   localparam logic [7:0] EN_Y   = 8'h20;
   localparam logic [7:0] EN_Z   = 8'h10;
   localparam logic [7:0] EN_MAR = 8'h08;
   localparam logic [7:0] EN_MDR = 8'h04;
   localparam logic [7:0] EN_HI  = 8'h02;
   localparam logic [7:0] EN_LO  = 8'h01;

   logic        clk, clr, run, mem_ready;
   logic [31:0] ir;
   logic [4:0]  bus_sel;
   logic [15:0] reg_in;
   logic        pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in;
   logic        inc_pc, mem_read, busy, halted, fault, illegal;
   logic [2:0]  alu_op;
   logic [3:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cycle_no = 0;

   datapath_sequencer #(.TIMEOUT(4)) dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
      .bus_sel(bus_sel), .reg_in(reg_in),
      .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
      .mar_in(mar_in), .mdr_in(mdr_in), .hi_in(hi_in), .lo_in(lo_in),
      .inc_pc(inc_pc), .alu_op(alu_op), .mem_read(mem_read),
      .busy(busy), .halted(halted), .fault(fault), .illegal(illegal),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected control word builder
   function automatic logic [W-1:0] w(input logic [3:0] st, input logic [4:0] bs,
                                      input logic [15:0] rg, input logic [7:0] en,
                                      input logic inc, input logic [2:0] aop,
                                      input logic mr, input logic flt, input logic ill);
      logic bz, hl;
      hl = (st == S_HALTED);
      bz = !(st == S_IDLE || hl);
      return {st, bs, rg, en, inc, aop, mr, bz, hl, flt, ill};
   endfunction

   function automatic logic [W-1:0] w_idle(input logic flt);
      return w(S_IDLE, 5'd31, 16'h0, 8'h0, 1'b0, 3'd0, 1'b0, flt, 1'b0);
   endfunction
   function automatic logic [W-1:0] w_t0();
      return w(S_T0, 5'd16, 16'h0, EN_MAR | EN_Z, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [W-1:0] w_t1(input logic rdy);
      return w(S_T1, 5'd20, 16'h0, rdy ? (EN_PC | EN_MDR) : EN_PC, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
   endfunction
   function automatic logic [W-1:0] w_t2();
      return w(S_T2, 5'd21, 16'h0, EN_IR, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [W-1:0] w_halt(input logic flt);
      return w(S_HALTED, 5'd31, 16'h0, 8'h0, 1'b0, 3'd0, 1'b0, flt, 1'b0);
   endfunction

   // driver: expect e during the current cycle, then advance to next cycle
   task automatic cyc(input logic [W-1:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string nm);
      cyc(w_t0(), {nm, "_t0"});
      cyc(w_t1(1'b1), {nm, "_t1"});
      cyc(w_t2(), {nm, "_t2"});
   endtask

   // scoreboard monitor
   initial begin
      logic [W-1:0] e, act;
      string nm;
      forever begin
         @(negedge clk);
         cycle_no++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {dbg_state, bus_sel, reg_in, pc_in, ir_in, y_in, z_in, mar_in,
                   mdr_in, hi_in, lo_in, inc_pc, alu_op, mem_read, busy, halted,
                   fault, illegal};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s (cycle %0d): got %h expected %h", nm, cycle_no, act, e);
            end
         end
      end
   end

   // stimulus
   initial begin
      clr = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      cyc(w_idle(1'b0), "reset");
      clr = 1'b1;
      for (int i = 0; i < 10; i++) cyc(w_idle(1'b0), "idle_hold");

      // ADD r0 = r2 + r1, run held high throughout
      ir = 32'h0010_8000;
      run = 1'b1;
      cyc(w_idle(1'b0), "add_start");
      fetch("add");
      cyc(w(S_T3, 5'd2, 16'h0, EN_Y, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "add_t3");
      cyc(w(S_T4, 5'd1, 16'h0, EN_Z, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "add_t4");
      cyc(w(S_T5, 5'd20, 16'h0001, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "add_t5");

      // SUB r5 = r5 - r5 with three memory wait cycles
      run = 1'b0;
      ir = 32'h0AAA_8000;
      mem_ready = 1'b0;
      cyc(w_t0(), "sub_t0");
      cyc(w_t1(1'b0), "wait1");
      cyc(w_t1(1'b0), "wait2");
      cyc(w_t1(1'b0), "wait3");
      mem_ready = 1'b1;
      cyc(w_t1(1'b1), "wait_done");
      cyc(w_t2(), "sub_t2");
      cyc(w(S_T3, 5'd5, 16'h0, EN_Y, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "sub_t3");
      cyc(w(S_T4, 5'd5, 16'h0, EN_Z, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0), "sub_t4");
      cyc(w(S_T5, 5'd20, 16'h0020, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "sub_t5");

      // asynchronous clear in the middle of T4
      ir = 32'h0010_8000;
      fetch("abort");
      cyc(w(S_T3, 5'd2, 16'h0, EN_Y, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "abort_t3");
      clr = 1'b0;
      cyc(w_idle(1'b0), "clr_mid_t4");
      clr = 1'b1;
      cyc(w_idle(1'b0), "after_clr");

      // MUL r3 = r4 * r6, then MFHI r7
      ir = 32'h21A3_0000;
      run = 1'b1;
      cyc(w_idle(1'b0), "mul_start");
      run = 1'b0;
      fetch("mul");
      cyc(w(S_T3, 5'd4, 16'h0, EN_Y, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "mul_t3");
      cyc(w(S_T4, 5'd6, 16'h0, EN_Z, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0), "mul_t4");
      cyc(w(S_T5, 5'd20, 16'h0, EN_LO, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "mul_t5");
      cyc(w(S_T6, 5'd19, 16'h0, EN_HI, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "mul_t6");
      ir = 32'h2B80_0000;
      fetch("mfhi");
      cyc(w(S_T3, 5'd17, 16'h0080, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "mfhi_t3");
      ir = 32'h3000_0000;
      fetch("mflo");
      cyc(w(S_T3, 5'd18, 16'h0001, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "mflo_t3");
      ir = 32'h3800_0000;
      fetch("nop");
      cyc(w(S_T3, 5'd31, 16'h0, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "nop_t3");
      ir = 32'h4800_0000;
      fetch("ill");
      cyc(w(S_T3, 5'd31, 16'h0, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1), "ill_t3");
      ir = 32'hF800_0000;
      fetch("halt");
      cyc(w(S_T3, 5'd31, 16'h0, 8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "halt_t3");
      for (int i = 0; i < 3; i++) cyc(w_halt(1'b0), "halted");
      run = 1'b1;
      cyc(w_halt(1'b0), "halted_run");
      run = 1'b0;
      for (int i = 0; i < 2; i++) cyc(w_halt(1'b0), "halted_stay");
      clr = 1'b0;
      cyc(w_idle(1'b0), "halt_clr");
      clr = 1'b1;

      // memory timeout with TIMEOUT=4
      run = 1'b1;
      cyc(w_idle(1'b0), "to_start");
      run = 1'b0;
      mem_ready = 1'b0;
      cyc(w_t0(), "to_t0");
      for (int i = 0; i < 4; i++) cyc(w_t1(1'b0), "to_wait");
      cyc(w_halt(1'b1), "to_fault");
      cyc(w_halt(1'b1), "to_fault_hold");
      run = 1'b1;
      cyc(w_halt(1'b1), "to_run_ignored");
      run = 1'b0;
      cyc(w_halt(1'b1), "to_still_halted");
      clr = 1'b0;
      cyc(w_idle(1'b0), "to_clr");
      clr = 1'b1;
      mem_ready = 1'b1;
      cyc(w_idle(1'b0), "to_idle");

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
